// File: rtl/spi_pkg.sv
// spi_pkg: shared types and constants for the SPI initiator.
// Mode 0 only: sclk idles low, data sampled on the rising edge.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    XFER,
    HOLD
  } spi_state_e;

  localparam logic CPOL = 1'b0;
  localparam logic CPHA = 1'b0;

  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_DATA_W  = 8;

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: free-running modulo-CLK_DIV counter.
// tick is high for one cycle on the terminal count while enabled.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign tick = en && (cnt == LAST);

endmodule

// File: rtl/spi_master_byte.sv
// spi_master_byte: mode-0 SPI initiator, one DATA_W-bit word per start.
// cs_n low spans SETUP, 2*DATA_W sclk half-periods and HOLD.
module spi_master_byte
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = DEF_CLK_DIV,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int LSB_FIRST = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] tx_data,
  output logic [DATA_W-1:0] rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              cs_n,
  output logic              mosi,
  input  logic              miso
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_W - 1);
  localparam bit LSBF = (LSB_FIRST != 0);

  spi_state_e state, state_d;

  logic [DATA_W-1:0] tx_sr, tx_sr_d;
  logic [DATA_W-1:0] rx_sr, rx_sr_d;
  logic [DATA_W-1:0] rx_data_d;
  logic [DATA_W-1:0] rx_shift;
  logic [BW-1:0]     bit_cnt, bit_cnt_d;
  logic              sclk_d, cs_n_d, mosi_d;
  logic              busy_d, done_d;
  logic              div_en, accept, tick;

  function automatic logic head(input logic [DATA_W-1:0] w);
    return LSBF ? w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] adv(input logic [DATA_W-1:0] w);
    return LSBF ? (w >> 1) : (w << 1);
  endfunction

  assign accept   = (state == IDLE) && start;
  assign div_en   = (state != IDLE);
  assign rx_shift = LSBF ? {miso, rx_sr[DATA_W-1:1]}
                         : {rx_sr[DATA_W-2:0], miso};

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_div (
    .clk (clk),
    .rst (rst),
    .en  (div_en),
    .clr (accept),
    .tick(tick)
  );

  always_comb begin
    state_d   = state;
    tx_sr_d   = tx_sr;
    rx_sr_d   = rx_sr;
    rx_data_d = rx_data;
    bit_cnt_d = bit_cnt;
    sclk_d    = sclk;
    cs_n_d    = cs_n;
    mosi_d    = mosi;
    busy_d    = busy;
    done_d    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d   = SETUP;
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          sclk_d    = CPOL;
          mosi_d    = head(tx_data);
          tx_sr_d   = adv(tx_data);
          rx_sr_d   = '0;
          bit_cnt_d = '0;
        end
      end
      SETUP: begin
        if (tick) state_d = XFER;
      end
      XFER: begin
        if (tick) begin
          if (!sclk) begin
            sclk_d  = 1'b1;
            rx_sr_d = rx_shift;
          end else begin
            sclk_d    = 1'b0;
            bit_cnt_d = bit_cnt + 1'b1;
            // last falling edge: mosi keeps the final bit through HOLD
            if (bit_cnt == LAST_BIT) begin
              state_d = HOLD;
            end else begin
              mosi_d  = head(tx_sr);
              tx_sr_d = adv(tx_sr);
            end
          end
        end
      end
      HOLD: begin
        if (tick) begin
          state_d   = IDLE;
          cs_n_d    = 1'b1;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
          rx_data_d = rx_sr;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_data <= '0;
      bit_cnt <= '0;
      sclk    <= CPOL;
      cs_n    <= 1'b1;
      mosi    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_d;
      tx_sr   <= tx_sr_d;
      rx_sr   <= rx_sr_d;
      rx_data <= rx_data_d;
      bit_cnt <= bit_cnt_d;
      sclk    <= sclk_d;
      cs_n    <= cs_n_d;
      mosi    <= mosi_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_spi_master_byte.sv
// tb_spi_master_byte: directed and random transfers on two configurations,
// observed at the pins and compared with a word-level expectation.
module tb_spi_master_byte;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // instance A: defaults (CLK_DIV=4, MSB first)
  logic       a_start = 1'b0;
  logic [7:0] a_tx = '0, a_rx, a_sw = '0;
  logic       a_busy, a_done, a_sclk, a_cs_n, a_mosi, a_miso;
  int         a_mode = 0;

  // instance B: CLK_DIV=2, LSB first
  logic       b_start = 1'b0;
  logic [7:0] b_tx = '0, b_rx, b_sw = '0;
  logic       b_busy, b_done, b_sclk, b_cs_n, b_mosi, b_miso;

  spi_master_byte u_a (
    .clk(clk), .rst(rst), .start(a_start), .tx_data(a_tx),
    .rx_data(a_rx), .busy(a_busy), .done(a_done), .sclk(a_sclk),
    .cs_n(a_cs_n), .mosi(a_mosi), .miso(a_miso)
  );

  spi_master_byte #(.CLK_DIV(2), .DATA_W(8), .LSB_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .tx_data(b_tx),
    .rx_data(b_rx), .busy(b_busy), .done(b_done), .sclk(b_sclk),
    .cs_n(b_cs_n), .mosi(b_mosi), .miso(b_miso)
  );

  // pin monitor A
  int a_rises = 0, a_low = 0, a_lastr = 0, a_pmin = 0, a_pmax = 0;
  int a_rises_last = 0, a_low_last = 0, a_pmin_last = 0, a_pmax_last = 0;
  int a_dcyc = 0, a_dt_last = 0, a_dt_prev = 0, a_hi = 0, a_hi_last = 0;
  logic [31:0] a_seq = '0, a_seq_last = '0;
  logic a_or = 1'b0, a_or_last = 1'b0, a_psclk = 1'b0, a_pcs = 1'b1;

  always @(negedge clk) begin
    a_psclk <= a_sclk;
    a_pcs   <= a_cs_n;
    a_hi    <= a_cs_n ? a_hi + 1 : 0;
    if (!a_cs_n && a_pcs) a_hi_last <= a_hi;
    if (a_cs_n) begin
      a_rises <= 0; a_seq <= '0; a_low <= 0; a_or <= 1'b0;
      a_pmin <= 1000; a_pmax <= 0;
      if (!a_pcs) begin
        a_low_last <= a_low; a_rises_last <= a_rises;
        a_seq_last <= a_seq; a_or_last <= a_or;
        a_pmin_last <= a_pmin; a_pmax_last <= a_pmax;
      end
    end else begin
      a_low <= a_low + 1;
      a_or  <= a_or | a_mosi;
      if (a_sclk && !a_psclk) begin
        a_rises <= a_rises + 1;
        a_seq   <= {a_seq[30:0], a_mosi};
        a_lastr <= cyc;
        if (a_rises > 0) begin
          if (cyc - a_lastr < a_pmin) a_pmin <= cyc - a_lastr;
          if (cyc - a_lastr > a_pmax) a_pmax <= cyc - a_lastr;
        end
      end
    end
    if (a_done) begin
      a_dcyc <= a_dcyc + 1; a_dt_prev <= a_dt_last; a_dt_last <= cyc;
    end
  end

  // pin monitor B
  int b_rises = 0, b_low = 0, b_lastr = 0, b_pmin = 0, b_pmax = 0;
  int b_rises_last = 0, b_low_last = 0, b_pmin_last = 0, b_pmax_last = 0;
  int b_dcyc = 0;
  logic [31:0] b_seq = '0, b_seq_last = '0;
  logic b_psclk = 1'b0, b_pcs = 1'b1;

  always @(negedge clk) begin
    b_psclk <= b_sclk;
    b_pcs   <= b_cs_n;
    if (b_cs_n) begin
      b_rises <= 0; b_seq <= '0; b_low <= 0; b_pmin <= 1000; b_pmax <= 0;
      if (!b_pcs) begin
        b_low_last <= b_low; b_rises_last <= b_rises; b_seq_last <= b_seq;
        b_pmin_last <= b_pmin; b_pmax_last <= b_pmax;
      end
    end else begin
      b_low <= b_low + 1;
      if (b_sclk && !b_psclk) begin
        b_rises <= b_rises + 1;
        b_seq   <= {b_seq[30:0], b_mosi};
        b_lastr <= cyc;
        if (b_rises > 0) begin
          if (cyc - b_lastr < b_pmin) b_pmin <= cyc - b_lastr;
          if (cyc - b_lastr > b_pmax) b_pmax <= cyc - b_lastr;
        end
      end
    end
    if (b_done) b_dcyc <= b_dcyc + 1;
  end

  // slave models: 0 loopback, 1 constant a_sw[0], 2 shift out a_sw MSB first
  always_comb begin
    a_miso = 1'b0;
    if (a_mode == 0) a_miso = a_mosi;
    else if (a_mode == 1) a_miso = a_sw[0];
    else if (a_rises < 8) a_miso = a_sw[3'(7 - a_rises)];
  end

  always_comb begin
    b_miso = 1'b0;
    if (b_rises < 8) b_miso = b_sw[3'(b_rises)];
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_a_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (a_done) seen = 1'b1;
    end
  endtask

  task automatic xfer_a(input logic [7:0] tx, input int mode,
                        input logic [7:0] sw, input bit poke);
    bit seen;
    int d0;
    logic [7:0] exp_rx;
    a_mode = mode;
    a_sw   = sw;
    d0     = a_dcyc;
    @(negedge clk);
    a_tx = tx; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0; a_tx = 8'($urandom);
    check("a_busy_on", a_busy, 1);
    check("a_cs_low", a_cs_n, 0);
    check("a_first_bit", a_mosi, tx[7]);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (poke && i == 8) begin
        a_start = 1'b1; a_tx = 8'h55;
      end else begin
        a_start = 1'b0;
      end
      if (a_done) seen = 1'b1;
    end
    a_start = 1'b0;
    check("a_done_seen", seen, 1);
    @(negedge clk);
    exp_rx = (mode == 0) ? tx : (mode == 1) ? {8{sw[0]}} : sw;
    check("a_rx_data", a_rx, exp_rx);
    check("a_mosi_word", a_seq_last, tx);
    check("a_sclk_rises", a_rises_last, 8);
    check("a_cs_low_len", a_low_last, 72);
    check("a_period_min", a_pmin_last, 8);
    check("a_period_max", a_pmax_last, 8);
    check("a_done_cycles", a_dcyc - d0, 1);
    check("a_busy_off", a_busy, 0);
    if (poke) begin
      repeat (5) @(negedge clk);
      check("a_no_queue", a_cs_n, 1);
    end
  endtask

  task automatic xfer_b(input logic [7:0] tx, input logic [7:0] sw);
    bit seen;
    int d0;
    logic [7:0] rev;
    for (int k = 0; k < 8; k++) rev[k] = tx[7-k];
    b_sw = sw;
    d0   = b_dcyc;
    @(negedge clk);
    b_tx = tx; b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    check("b_first_bit", b_mosi, tx[0]);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (b_done) seen = 1'b1;
    end
    check("b_done_seen", seen, 1);
    @(negedge clk);
    check("b_rx_data", b_rx, sw);
    check("b_mosi_word", b_seq_last, rev);
    check("b_sclk_rises", b_rises_last, 8);
    check("b_cs_low_len", b_low_last, 36);
    check("b_period_min", b_pmin_last, 4);
    check("b_period_max", b_pmax_last, 4);
    check("b_done_cycles", b_dcyc - d0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    bit seen;
    int d0;
    logic [7:0] t1, t2;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", a_cs_n, 1);
    check("rst_sclk", a_sclk, 0);
    check("rst_mosi", a_mosi, 0);
    check("rst_busy", a_busy, 0);
    check("rst_done", a_done, 0);
    check("rst_rx", a_rx, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    xfer_a(8'hA9, 0, 8'h00, 1'b0);

    xfer_a(8'h00, 1, 8'h01, 1'b0);
    check("mosi_zero_word", a_or_last, 0);
    xfer_a(8'hFF, 1, 8'h00, 1'b0);

    xfer_a(8'h3C, 0, 8'h00, 1'b1);

    // reset after the third rising sclk edge
    a_mode = 0;
    d0 = a_dcyc;
    @(negedge clk);
    a_tx = 8'hC6; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (a_rises == 3) seen = 1'b1;
    end
    check("abort_reach_rise3", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    check("abort_cs_n", a_cs_n, 1);
    check("abort_sclk", a_sclk, 0);
    check("abort_busy", a_busy, 0);
    check("abort_rx", a_rx, 0);
    check("abort_done", a_done, 0);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("abort_no_done", a_dcyc - d0, 0);
    xfer_a(8'h5A, 2, 8'hC3, 1'b0);

    // back-to-back with start held across done
    t1 = 8'($urandom);
    t2 = 8'($urandom);
    a_mode = 0;
    d0 = a_dcyc;
    @(negedge clk);
    a_tx = t1; a_start = 1'b1;
    wait_a_done(seen);
    check("b2b_done1", seen, 1);
    a_tx = t2;
    @(negedge clk);
    a_start = 1'b0;
    check("b2b_rx1", a_rx, t1);
    check("b2b_restart", a_cs_n, 0);
    wait_a_done(seen);
    check("b2b_done2", seen, 1);
    @(negedge clk);
    check("b2b_pulses", a_dcyc - d0, 2);
    check("b2b_spacing", a_dt_last - a_dt_prev, 73);
    check("b2b_cs_gap", a_hi_last, 1);
    check("b2b_mosi2", a_seq_last, t2);
    check("b2b_rx2", a_rx, t2);
    check("b2b_low2", a_low_last, 72);

    for (int n = 0; n < 6; n++)
      xfer_a(8'($urandom), (n % 2 == 0) ? 0 : 2, 8'($urandom), 1'b0);

    xfer_b(8'($urandom), 8'h81);
    for (int n = 0; n < 4; n++)
      xfer_b(8'($urandom), 8'($urandom));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
